// File: rtl/demux_gate_sequencer.sv
// Serial gate evaluator time-sharing one 1x2 demux over a micro-sequence.
// Optional macro DEMUX_SEQ_BACK2BACK_EN: accept next request during response.
module demux_1x2 (
    input  logic in_i,
    input  logic sel_i,
    output logic out0_o,
    output logic out1_o
);
    assign out0_o = in_i & ~sel_i;
    assign out1_o = in_i & sel_i;
endmodule

module demux_gate_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic             a,
    input  logic             b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             result,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {D_T0, D_T1, D_RES} dest_t;

    state_t            state_q;
    logic [2:0]        step_q;
    logic [2:0]        op_q;
    logic              a_q, b_q, t0_q, t1_q;
    logic              result_q;
    logic [CNT_W-1:0]  done_cnt_q;

    logic  dm_in, dm_sel, dm_out0, dm_out1, dm_out;
    logic  use_out1, last;
    dest_t dest;

    demux_1x2 u_dmx (
        .in_i   (dm_in),
        .sel_i  (dm_sel),
        .out0_o (dm_out0),
        .out1_o (dm_out1)
    );

    assign dm_out = use_out1 ? dm_out1 : dm_out0;

    // Micro-step table: only steers the demux inputs and picks the destination.
    always_comb begin
        dm_in    = 1'b1;
        dm_sel   = a_q;
        use_out1 = 1'b0;
        dest     = D_RES;
        last     = 1'b1;
        unique case (op_q)
            3'd0: ;
            3'd1: use_out1 = 1'b1;
            3'd2: begin
                dm_in    = b_q;
                use_out1 = 1'b1;
            end
            3'd3: begin
                case (step_q)
                    3'd0: begin
                        dm_sel = b_q;
                        dest   = D_T0;
                        last   = 1'b0;
                    end
                    3'd1: begin
                        dm_in = t0_q;
                        dest  = D_T1;
                        last  = 1'b0;
                    end
                    default: dm_sel = t1_q;
                endcase
            end
            3'd4: begin
                if (step_q == 3'd0) begin
                    dm_in    = b_q;
                    use_out1 = 1'b1;
                    dest     = D_T0;
                    last     = 1'b0;
                end else begin
                    dm_sel = t0_q;
                end
            end
            3'd5: begin
                if (step_q == 3'd0) begin
                    dest = D_T0;
                    last = 1'b0;
                end else begin
                    dm_in  = t0_q;
                    dm_sel = b_q;
                end
            end
            3'd6, 3'd7: begin
                last = 1'b0;
                case (step_q)
                    3'd0: begin
                        dm_in = b_q;
                        dest  = D_T0;
                    end
                    3'd1: begin
                        dm_sel = t0_q;
                        dest   = D_T0;
                    end
                    3'd2: begin
                        dm_in  = a_q;
                        dm_sel = b_q;
                        dest   = D_T1;
                    end
                    3'd3: begin
                        dm_in  = t0_q;
                        dm_sel = t1_q;
                        dest   = (op_q == 3'd7) ? D_T1 : D_RES;
                        last   = (op_q == 3'd6);
                    end
                    default: begin
                        dm_sel = t1_q;
                        last   = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            op_q       <= 3'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            t0_q       <= 1'b0;
            t1_q       <= 1'b0;
            result_q   <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        step_q  <= 3'd0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (last) begin
                        result_q <= dm_out;
                        step_q   <= 3'd0;
                        state_q  <= RESP;
                    end else begin
                        step_q <= step_q + 3'd1;
                        if (dest == D_T0) t0_q <= dm_out;
                        if (dest == D_T1) t1_q <= dm_out;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        done_cnt_q <= done_cnt_q + 1'b1;
                        state_q    <= IDLE;
`ifdef DEMUX_SEQ_BACK2BACK_EN
                        if (req_valid) begin
                            op_q    <= op;
                            a_q     <= a;
                            b_q     <= b;
                            step_q  <= 3'd0;
                            state_q <= EXEC;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_SEQ_BACK2BACK_EN
    assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
`else
    assign req_ready = (state_q == IDLE);
`endif
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_demux_gate_sequencer.sv
// Directed bench for demux_gate_sequencer; honours DEMUX_SEQ_BACK2BACK_EN.
module tb_demux_gate_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [2:0] op = 3'd0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       req_ready, rsp_valid, result, busy;
    logic [7:0] done_cnt;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_cnt = 8'd0;

    demux_gate_sequencer #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic gate(input logic [2:0] o, input logic x,
                                  input logic y);
        case (o)
            3'd0: return ~x;
            3'd1: return x;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return x ^ y;
        endcase
    endfunction

    function automatic int steps(input logic [2:0] o);
        case (o)
            3'd3: return 3;
            3'd4: return 2;
            3'd5: return 2;
            3'd6: return 4;
            3'd7: return 5;
            default: return 1;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic x, input logic y,
                         input bit toggle, input int hold);
        string t;
        logic  er;
        int    n;
        t  = $sformatf("op%0d a%0d b%0d", o, x, y);
        er = gate(o, x, y);
        @(negedge clk);
        check({t, " req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        op = o; a = x; b = y;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            if (toggle) begin
                op = 3'($urandom);
                a  = ~a;
                b  = ~b;
            end
            @(negedge clk);
            n++;
        end
        check({t, " latency"}, n, steps(o));
        check({t, " rsp_valid"}, rsp_valid, 1);
        check({t, " result"}, result, er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({t, " hold rsp_valid"}, rsp_valid, 1);
            check({t, " hold result"}, result, er);
            check({t, " hold req_ready"}, req_ready, 0);
            check({t, " hold done_cnt"}, done_cnt, exp_cnt);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check({t, " done_cnt"}, done_cnt, exp_cnt);
        check({t, " rsp_valid low"}, rsp_valid, 0);
    endtask

    initial begin
        int acc, r1, r2, a2, gap, aoff;
        #12;
        check("rst req_ready", req_ready, 1);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst result", result, 0);
        check("rst busy", busy, 0);
        check("rst done_cnt", done_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd2, 1'b1, 1'b1, 1'b0, 0);

        for (int o = 0; o < 8; o++)
            for (int v = 0; v < 4; v++)
                do_op(3'(o), v[1], v[0], 1'b0, 0);

        do_op(3'd7, 1'b0, 1'b1, 1'b1, 0);
        do_op(3'd3, 1'b1, 1'b0, 1'b0, 10);

        @(negedge clk);
        req_valid = 1'b1;
        op = 3'd6; a = 1'b1; b = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst req_ready", req_ready, 1);
        check("arst rsp_valid", rsp_valid, 0);
        check("arst result", result, 0);
        check("arst busy", busy, 0);
        check("arst done_cnt", done_cnt, 0);
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd4, 1'b0, 1'b1, 1'b0, 0);

`ifdef DEMUX_SEQ_BACK2BACK_EN
        gap = 2;
        aoff = 0;
`else
        gap = 3;
        aoff = 1;
`endif
        @(negedge clk);
        op = 3'd2; a = 1'b1; b = 1'b1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        acc = 0; r1 = -1; r2 = -1; a2 = -1;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid && rsp_ready) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) a2 = i;
            end
            @(posedge clk);
            #1;
            if (acc == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd2;
        check("b2b accepts", acc, 2);
        check("b2b rsp gap", r2 - r1, gap);
        check("b2b 2nd accept", a2 - r1, aoff);
        check("b2b done_cnt", done_cnt, exp_cnt);
        check("b2b result", result, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
